fsm_sync_mc: RTL and testbench
==============================

Name: fsm_sync_mc

Overview:
Multi-channel, parametrised RF-arrival synchroniser for the shift/readout path. Each channel captures an RF input event on either clock edge, holds an ACTIVE flag until the shift sequence completes, an abort occurs, or a programmable timeout expires. Adds per-channel enable, timeout with sticky status, re-arm lockout and saturating event counters for the control/readout logic downstream.

Parameters:
N_CH, 4, number of independent RF channels
TMO_W, 8, width of timeout counter and tmo_val
CNT_W, 8, width of each per-channel event counter

Ports:
clk  in  1  system clock; both edges used
rst  in  1  reset, synchronous, active-low, clock clk (sampled on each edge by the flops of that edge)
rfin  in  N_CH  RF event inputs, level
ch_en  in  N_CH  per-channel capture enable
sh_en  in  1  shift enable; its falling edge ends ACTIVE on all channels
fsm_rst  in  1  abort; forces all channels IDLE
tmo_val  in  TMO_W  timeout in posedge cycles; 0 = timeout disabled
clr_status  in  1  clears tmo_flag and evt_cnt
active  out  N_CH  per-channel ACTIVE = st_pos[i] | st_neg[i], registered OR, no combinational path from rfin
any_active  out  1  OR of active
tmo_flag  out  N_CH  sticky timeout status
evt_cnt  out  N_CH*CNT_W  per-channel saturating event count, channel i at bits [i*CNT_W +: CNT_W]

Behaviour:
- Reset (rst=0): st_pos, sh_en_q, tcnt, lock, active_q, tmo_flag, evt_cnt -> 0 at posedge; st_neg -> 0 at negedge. All outputs 0 once both edges have seen reset.
- sh_end = ~sh_en & sh_en_q; sh_en_q is the posedge-registered sh_en.
- Per channel i, two identical 2-state FSMs (IDLE=0, ACTIVE=1): st_pos on posedge, st_neg on negedge. Both use the same next-state function:
  - IDLE -> ACTIVE when rfin[i] & ch_en[i] & ~lock[i].
  - ACTIVE -> IDLE when sh_end | fsm_rst | tmo_hit[i]. Otherwise hold.
  - Exit conditions beat entry. A channel in IDLE with rfin high and fsm_rst high stays IDLE.
- Capture latency: rfin rise is seen by the first clk edge of either polarity, so active rises ≤ half a cycle after that edge.
- Timeout: tcnt[i] is posedge, TMO_W bits.
  - Clears when active[i]=0; increments while active[i]=1, saturating.
  - tmo_hit[i] = (tmo_val != 0) & (tcnt[i] >= tmo_val), combinational from registers.
  - On the posedge where tmo_hit[i] & active[i]: tmo_flag[i] <= 1 and lock[i] <= 1.
- Lockout: lock[i] clears at a posedge where rfin[i]=0, which prevents immediate re-arm on a stuck-high rfin. sh_end and fsm_rst exits do not set lock.
- ch_en[i]=0 blocks only entry; an ACTIVE channel stays until a normal exit.
- Event count: active_q is posedge-registered active. evt_cnt[i] increments at a posedge where active[i] & ~active_q[i], saturating at all-ones.
- clr_status at a posedge clears tmo_flag and evt_cnt. If it coincides with a set or increment event, clear wins.
- sh_end or fsm_rst while already IDLE: no effect. tmo_val changed mid-ACTIVE: the new value takes effect immediately in the compare.
- Reset mid-ACTIVE: channel returns IDLE. No flag or count is recorded for the aborted event.

Test Plan:
1. Reset then rfin[0] pulse high across one negedge only (tmo_val=0) -> active[0]=1 after that negedge; active[1..3]=0; evt_cnt[0]=1 after next posedge.
2. Channel 0 ACTIVE; sh_en 1->0 -> active[0]=0 within one cycle of the posedge sampling sh_en low; tmo_flag=0.
3. tmo_val=5, rfin[2] held high -> active[2] drops ~5 cycles after rise; tmo_flag[2]=1; stays IDLE while rfin high; re-enters one edge after rfin low then high again; evt_cnt[2]=2.
4. ch_en=4'b1011, rfin=4'hF -> active=4'b1011. fsm_rst=1 with rfin held -> active=0 while fsm_rst=1.
5. 300 events on channel 1 with CNT_W=8 -> evt_cnt[1]=255. clr_status coincident with an event -> evt_cnt[1]=0, tmo_flag=0.
6. rst=0 asserted mid-ACTIVE on all channels -> all outputs 0 after the next posedge plus negedge; no flag or count change.

Source files
------------

// File: rtl/fsm_sync_mc.sv
// ---------------------------------------------------------------------------
// fsm_sync_mc
//
// Multi-channel RF-arrival synchroniser for the shift/readout path. Each
// channel runs two copies of the same IDLE/ACTIVE state machine: one clocked
// on the rising edge and one on the falling edge. An RF event is therefore
// caught by whichever clock edge comes first. The channel is ACTIVE while
// either copy is ACTIVE.
//
// The block also provides:
//   - per-channel capture enable
//   - a programmable timeout with a sticky status flag
//   - a re-arm lockout after a timeout (so a stuck-high input cannot re-fire)
//   - saturating per-channel event counters
//
// Ports
//   clk         system clock; both edges are used
//   rst         synchronous, active-low reset. Each flop samples it on its
//               own clock edge.
//   rfin        RF event inputs (level), one per channel
//   ch_en       per-channel capture enable (blocks entry only)
//   sh_en       shift enable; its falling edge ends ACTIVE on all channels
//   fsm_rst     abort; forces every channel to IDLE
//   tmo_val     timeout in rising-edge cycles; 0 disables the timeout
//   clr_status  clears tmo_flag and evt_cnt (wins over set/increment)
//   active      per-channel ACTIVE (OR of the two edge state registers)
//   any_active  OR of active
//   tmo_flag    sticky per-channel timeout status
//   evt_cnt     saturating event counts, channel i at [i*CNT_W +: CNT_W]
// ---------------------------------------------------------------------------
module fsm_sync_mc #(
    parameter int N_CH  = 4,
    parameter int TMO_W = 8,
    parameter int CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_CH-1:0]       rfin,
    input  logic [N_CH-1:0]       ch_en,
    input  logic                  sh_en,
    input  logic                  fsm_rst,
    input  logic [TMO_W-1:0]      tmo_val,
    input  logic                  clr_status,
    output logic [N_CH-1:0]       active,
    output logic                  any_active,
    output logic [N_CH-1:0]       tmo_flag,
    output logic [N_CH*CNT_W-1:0] evt_cnt
);

    typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

    localparam logic [TMO_W-1:0] TMO_ONE = TMO_W'(1);
    localparam logic [TMO_W-1:0] TMO_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           st_pos [N_CH];
    state_t           st_neg [N_CH];
    logic [TMO_W-1:0] tcnt   [N_CH];
    logic [CNT_W-1:0] cnt    [N_CH];
    logic             sh_en_q;
    logic [N_CH-1:0]  lock;
    logic [N_CH-1:0]  active_q;
    logic [N_CH-1:0]  tmo_hit;
    logic [N_CH-1:0]  leave;
    logic [N_CH-1:0]  arm;
    logic             sh_end;

    // Shared next-state rule for both edge copies. In IDLE, any exit
    // condition suppresses entry, so exits always beat entries.
    function automatic state_t next_state(state_t cur, logic go, logic stop);
        case (cur)
            IDLE:    next_state = (go && !stop) ? ACTIVE : IDLE;
            default: next_state = stop ? IDLE : ACTIVE;
        endcase
    endfunction

    // All decode is taken from registers and inputs. active comes only from
    // the state flops, so there is no combinational path from rfin.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        active  = '0;
        tmo_hit = '0;
        leave   = '0;
        arm     = '0;
        evt_cnt = '0;
        sh_end  = ~sh_en & sh_en_q;
        for (int i = 0; i < N_CH; i++) begin
            active[i]  = (st_pos[i] == ACTIVE) | (st_neg[i] == ACTIVE);
            tmo_hit[i] = (tmo_val != '0) && (tcnt[i] >= tmo_val);
            leave[i]   = sh_end | fsm_rst | tmo_hit[i];
            arm[i]     = rfin[i] & ch_en[i] & ~lock[i];
            evt_cnt[i*CNT_W +: CNT_W] = cnt[i];
        end
    end

    assign any_active = |active;

    // Rising-edge state: edge FSM copy, timeout, lockout, status, counters.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // right-hand side below sees the pre-edge value.
        if (!rst) begin
            sh_en_q  <= 1'b0;
            lock     <= '0;
            active_q <= '0;
            tmo_flag <= '0;
            // NOTE: tcnt and cnt are small per-channel flop banks rather than
            // RAM, so they are reset together with the rest of the state.
            for (int i = 0; i < N_CH; i++) begin
                st_pos[i] <= IDLE;
                tcnt[i]   <= '0;
                cnt[i]    <= '0;
            end
        end else begin
            sh_en_q  <= sh_en;
            active_q <= active;
            for (int i = 0; i < N_CH; i++) begin
                st_pos[i] <= next_state(st_pos[i], arm[i], leave[i]);

                if (!active[i])
                    tcnt[i] <= '0;
                else if (tcnt[i] != TMO_MAX)
                    tcnt[i] <= tcnt[i] + TMO_ONE;

                // A timeout arms the lockout. The lockout is released only
                // once rfin has been seen low.
                lock[i] <= (tmo_hit[i] & active[i]) | (lock[i] & rfin[i]);

                if (clr_status) begin
                    tmo_flag[i] <= 1'b0;
                    cnt[i]      <= '0;
                end else begin
                    if (tmo_hit[i] && active[i])
                        tmo_flag[i] <= 1'b1;
                    if (active[i] && !active_q[i] && cnt[i] != CNT_MAX)
                        cnt[i] <= cnt[i] + CNT_ONE;
                end
            end
        end
    end

    // Falling-edge copy of the channel FSMs. It uses the same next-state rule
    // and the same rising-edge registered lock, timeout and sh_en_q.
    always_ff @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < N_CH; i++)
                st_neg[i] <= IDLE;
        end else begin
            for (int i = 0; i < N_CH; i++)
                st_neg[i] <= next_state(st_neg[i], arm[i], leave[i]);
        end
    end

endmodule

// File: tb/tb_fsm_sync_mc.sv
// ---------------------------------------------------------------------------
// tb_fsm_sync_mc
//
// Self-checking bench for fsm_sync_mc. A behavioural model updates on every
// clock edge. It keeps each channel as two "armed" booleans (one per clock
// edge) plus integer timers and counters. A compare process checks all DUT
// outputs against the model 2 ns after every edge. Stimulus changes 3 ns
// after an edge. Directed scenarios pin the model with literal values, then
// a randomized phase runs.
// ---------------------------------------------------------------------------
module tb_fsm_sync_mc;

    localparam int N_CH  = 4;
    localparam int TMO_W = 8;
    localparam int CNT_W = 8;
    localparam int TMO_MAX = (1 << TMO_W) - 1;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [N_CH-1:0]       rfin;
    logic [N_CH-1:0]       ch_en;
    logic                  sh_en;
    logic                  fsm_rst;
    logic [TMO_W-1:0]      tmo_val;
    logic                  clr_status;
    logic [N_CH-1:0]       active;
    logic                  any_active;
    logic [N_CH-1:0]       tmo_flag;
    logic [N_CH*CNT_W-1:0] evt_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    fsm_sync_mc #(.N_CH(N_CH), .TMO_W(TMO_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .rfin       (rfin),
        .ch_en      (ch_en),
        .sh_en      (sh_en),
        .fsm_rst    (fsm_rst),
        .tmo_val    (tmo_val),
        .clr_status (clr_status),
        .active     (active),
        .any_active (any_active),
        .tmo_flag   (tmo_flag),
        .evt_cnt    (evt_cnt)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit m_pos  [N_CH];   // channel armed by the rising-edge copy
    bit m_neg  [N_CH];   // channel armed by the falling-edge copy
    bit m_lock [N_CH];
    bit m_prev [N_CH];   // active as seen at the previous rising edge
    bit m_flag [N_CH];
    int m_tc   [N_CH];   // rising edges spent active
    int m_cnt  [N_CH];
    bit m_shq;

    function automatic bit m_active(int i);
        return m_pos[i] || m_neg[i];
    endfunction

    function automatic bit m_hit(int i);
        return (tmo_val != 0) && (m_tc[i] >= int'(tmo_val));
    endfunction

    function automatic bit m_stop(int i);
        return (!sh_en && m_shq) || fsm_rst || m_hit(i);
    endfunction

    // An armed copy stays armed unless a stop condition holds. A disarmed copy
    // arms on an enabled, unlocked rfin, but only if no stop condition holds.
    function automatic bit m_next(bit armed, int i);
        if (m_stop(i)) return 1'b0;
        if (armed) return 1'b1;
        return rfin[i] && ch_en[i] && !m_lock[i];
    endfunction

    task automatic model_pos();
        bit n_pos  [N_CH];
        bit n_lock [N_CH];
        bit n_flag [N_CH];
        bit n_prev [N_CH];
        int n_tc   [N_CH];
        int n_cnt  [N_CH];
        for (int i = 0; i < N_CH; i++) begin
            bit act;
            bit to;
            act       = m_active(i);
            to        = act && m_hit(i);
            n_pos[i]  = m_next(m_pos[i], i);
            n_tc[i]   = !act ? 0 : (m_tc[i] >= TMO_MAX ? TMO_MAX : m_tc[i] + 1);
            n_lock[i] = to || (m_lock[i] && rfin[i]);
            n_prev[i] = act;
            n_flag[i] = clr_status ? 1'b0 : (m_flag[i] || to);
            if (clr_status)
                n_cnt[i] = 0;
            else if (act && !m_prev[i] && m_cnt[i] < CNT_MAX)
                n_cnt[i] = m_cnt[i] + 1;
            else
                n_cnt[i] = m_cnt[i];
        end
        for (int i = 0; i < N_CH; i++) begin
            m_pos[i]  = rst ? n_pos[i]  : 1'b0;
            m_tc[i]   = rst ? n_tc[i]   : 0;
            m_lock[i] = rst ? n_lock[i] : 1'b0;
            m_prev[i] = rst ? n_prev[i] : 1'b0;
            m_flag[i] = rst ? n_flag[i] : 1'b0;
            m_cnt[i]  = rst ? n_cnt[i]  : 0;
        end
        m_shq = rst ? sh_en : 1'b0;
    endtask

    task automatic model_neg();
        bit n_neg [N_CH];
        for (int i = 0; i < N_CH; i++)
            n_neg[i] = m_next(m_neg[i], i);
        for (int i = 0; i < N_CH; i++)
            m_neg[i] = rst ? n_neg[i] : 1'b0;
    endtask

    always @(posedge clk or negedge clk) begin
        if (clk) model_pos();
        else     model_neg();
    end

    function automatic logic [N_CH-1:0] exp_active();
        logic [N_CH-1:0] v;
        for (int i = 0; i < N_CH; i++) v[i] = m_active(i);
        return v;
    endfunction

    function automatic logic [N_CH-1:0] exp_flag();
        logic [N_CH-1:0] v;
        for (int i = 0; i < N_CH; i++) v[i] = m_flag[i];
        return v;
    endfunction

    function automatic logic [N_CH*CNT_W-1:0] exp_cnt();
        logic [N_CH*CNT_W-1:0] v;
        for (int i = 0; i < N_CH; i++) v[i*CNT_W +: CNT_W] = CNT_W'(m_cnt[i]);
        return v;
    endfunction

    // Compare process: every edge, 2 ns after it.
    initial begin
        forever begin
            @(clk);
            #2;
            if (chk_en) begin
                check("model_active", active, exp_active());
                check("model_any_active", any_active, |exp_active());
                check("model_tmo_flag", tmo_flag, exp_flag());
                check("model_evt_cnt", evt_cnt, exp_cnt());
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic at_pos();
        @(posedge clk);
        #3;
    endtask

    task automatic at_neg();
        @(negedge clk);
        #3;
    endtask

    task automatic fire_ch1();
        rfin = 4'b0010;
        at_neg();
        rfin = '0;
        at_pos();
        fsm_rst = 1'b1;
        at_pos();
        fsm_rst = 1'b0;
    endtask

    initial begin
        rst = 1'b0; rfin = '0; ch_en = '1; sh_en = 1'b0; fsm_rst = 1'b0;
        tmo_val = '0; clr_status = 1'b0;
        repeat (3) at_pos();
        check("reset_active", active, 4'h0);
        check("reset_any_active", any_active, 1'b0);
        check("reset_tmo_flag", tmo_flag, 4'h0);
        check("reset_evt_cnt", evt_cnt, 32'h0);
        chk_en = 1'b1;
        rst = 1'b1;
        at_pos();

        // Scenario 1: rfin[0] high across one falling edge only.
        rfin = 4'b0001;
        sh_en = 1'b1;
        at_neg();
        rfin = '0;
        check("t1_active_after_negedge", active, 4'b0001);
        at_pos();
        check("t1_evt_cnt0", evt_cnt[0 +: CNT_W], 8'd1);
        check("t1_active_held", active, 4'b0001);

        // Scenario 2: sh_en falls, which ends ACTIVE.
        sh_en = 1'b0;
        at_neg();
        at_pos();
        check("t2_active_after_sh_end", active, 4'b0000);
        check("t2_tmo_flag", tmo_flag, 4'b0000);

        // Scenario 3: timeout with stuck-high rfin[2], lockout, then re-arm.
        tmo_val = 8'd5;
        rfin = 4'b0100;
        repeat (10) at_pos();
        check("t3_locked_idle", active, 4'b0000);
        check("t3_tmo_flag", tmo_flag, 4'b0100);
        check("t3_evt_cnt2_first", evt_cnt[2*CNT_W +: CNT_W], 8'd1);
        rfin = '0;
        at_pos();
        rfin = 4'b0100;
        at_neg();
        check("t3_rearm", active, 4'b0100);
        at_pos();
        check("t3_evt_cnt2_second", evt_cnt[2*CNT_W +: CNT_W], 8'd2);
        rfin = '0;
        fsm_rst = 1'b1;
        at_pos();
        check("t3_abort", active, 4'b0000);
        fsm_rst = 1'b0;
        tmo_val = '0;

        // Scenario 4: channel enables, then abort with rfin held high.
        ch_en = 4'b1011;
        rfin = 4'hF;
        at_neg();
        check("t4_enabled_active", active, 4'b1011);
        at_pos();
        fsm_rst = 1'b1;
        at_pos();
        check("t4_abort_pos", active, 4'b0000);
        at_neg();
        check("t4_abort_neg", active, 4'b0000);
        at_pos();
        check("t4_abort_hold", active, 4'b0000);
        fsm_rst = 1'b0;
        rfin = '0;
        ch_en = '1;

        // Scenario 5: counter saturation, then a clear coincident with an event.
        for (int k = 0; k < 300; k++) fire_ch1();
        check("t5_evt_cnt1_sat", evt_cnt[1*CNT_W +: CNT_W], 8'd255);
        rfin = 4'b0010;
        at_neg();
        rfin = '0;
        clr_status = 1'b1;
        at_pos();
        clr_status = 1'b0;
        check("t5_clear_wins_cnt", evt_cnt, 32'h0);
        check("t5_clear_flag", tmo_flag, 4'h0);
        fsm_rst = 1'b1;
        at_pos();
        fsm_rst = 1'b0;

        // Scenario 6: reset while every channel is ACTIVE.
        rfin = 4'hF;
        at_neg();
        at_pos();
        check("t6_all_active", active, 4'hF);
        check("t6_counts", evt_cnt, 32'h01010101);
        rst = 1'b0;
        at_neg();
        at_pos();
        check("t6_reset_active", active, 4'h0);
        check("t6_reset_any", any_active, 1'b0);
        check("t6_reset_flag", tmo_flag, 4'h0);
        check("t6_reset_cnt", evt_cnt, 32'h0);
        rst = 1'b1;
        rfin = '0;

        // Randomized phase: inputs change after every edge.
        for (int k = 0; k < 3000; k++) begin
            if (k % 2 == 0) at_pos();
            else            at_neg();
            if ($urandom_range(0, 3) == 0) rfin = N_CH'($urandom);
            if ($urandom_range(0, 15) == 0) ch_en = N_CH'($urandom);
            if ($urandom_range(0, 11) == 0) sh_en = ~sh_en;
            fsm_rst = ($urandom_range(0, 39) == 0);
            clr_status = ($urandom_range(0, 59) == 0);
            rst = ($urandom_range(0, 499) != 0);
            if ($urandom_range(0, 49) == 0)
                tmo_val = ($urandom_range(0, 3) == 0) ? '0 : TMO_W'($urandom_range(1, 8));
        end
        rst = 1'b1;
        at_pos();
        at_neg();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
